// File: rtl/rvecc_encode_wr.sv
// rvecc_encode_wr
//   Write-path SECDED encoder for a 32-bit ECC-protected SRAM. It computes
//   the 7-bit (39,32) check code that the read-path decoder expects. Byte-masked
//   stores go through a read-modify-write: read the word (already corrected by
//   the read-path decoder), merge the new bytes, re-encode, write back.
//
// Optional feature (macro RVECC_ERR_INJECT_EN):
//   Adds inj_arm / inj_bit. A pulse on inj_arm arms a one-shot flip of codeword
//   bit inj_bit (0-31 data, 32-38 ecc[0..6]) on the next write strobe.
//   inj_bit > 38 is ignored. Without the macro every write is clean.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     store request handshake
//   req_addr/wdata/be   store word address, data, byte enables (bit k = byte k)
//   mem_rd_en/rd_addr   SRAM read strobe and address (RMW only)
//   rd_data             corrected read data, valid the cycle after mem_rd_en
//   rd_single_err       read data was single-bit corrected
//   rd_double_err       read data uncorrectable
//   mem_wr_en/addr/data/ecc  SRAM write strobe, address, data, check bits
//   rmw_corrected       one-cycle pulse with the write: merge used corrected data
//   rmw_abort           one-cycle pulse: RMW dropped on a double error
//
// Handshake: a store transfers on a rising edge where req_valid and req_ready
// are both high. req_ready depends only on state and rst (never on req_valid),
// and the requester must hold addr/wdata/be stable while req_valid waits.
//
// All strobes and their address/data are registered; they are non-zero only in
// the strobe cycle. The internal FSM state is the signal 'state'.

module rvecc_encode_wr #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   rd_data,
  input  logic          rd_single_err,
  input  logic          rd_double_err,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic [6:0]    mem_wr_ecc,
  output logic          rmw_corrected,
  output logic          rmw_abort
`ifdef RVECC_ERR_INJECT_EN
  ,
  input  logic          inj_arm,
  input  logic [5:0]    inj_bit
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_MRG  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          lat_load;

  logic          rd_en_n;
  logic [AW-1:0] rd_addr_n;
  logic          wr_en_n;
  logic [AW-1:0] wr_addr_n;
  logic [31:0]   wr_data_n;
  logic          corr_n;
  logic          abort_n;
  logic [31:0]   merged;
  logic [38:0]   inj_mask;
  logic [38:0]   cw_n;

  function automatic logic [6:0] ecc_encode(input logic [31:0] d);
    logic [6:0] e;
    e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^
           d[15] ^ d[17] ^ d[19] ^ d[21] ^ d[23] ^ d[25] ^ d[26] ^ d[28] ^ d[30];
    e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13] ^
           d[16] ^ d[17] ^ d[20] ^ d[21] ^ d[24] ^ d[25] ^ d[27] ^ d[28] ^ d[31];
    e[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15] ^
           d[16] ^ d[17] ^ d[22] ^ d[23] ^ d[24] ^ d[25] ^ d[29] ^ d[30] ^ d[31];
    e[3] = (^d[10:4]) ^ (^d[25:18]);
    e[4] = ^d[25:11];
    e[5] = ^d[31:26];
    // Overall parity bit: makes the whole 39-bit codeword even.
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  // Byte merge: enabled bytes from the store, the rest from the corrected read.
  always_comb begin
    merged = rd_data;
    for (int k = 0; k < 4; k++) begin
      if (lat_be[k]) merged[8*k +: 8] = lat_wdata[8*k +: 8];
    end
  end

  // Next-state and next-output logic. Outputs are registered, so each value
  // computed here appears on the ports one cycle later (e.g. mem_rd_en is
  // computed on acceptance and is visible while the FSM sits in S_RD).
  always_comb begin
    state_next = state;
    lat_load   = 1'b0;
    rd_en_n    = 1'b0;
    rd_addr_n  = '0;
    wr_en_n    = 1'b0;
    wr_addr_n  = '0;
    wr_data_n  = '0;
    corr_n     = 1'b0;
    abort_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_be == 4'hF) begin
            wr_en_n   = 1'b1;
            wr_addr_n = req_addr;
            wr_data_n = req_wdata;
          end else if (req_be != 4'h0) begin
            lat_load   = 1'b1;
            rd_en_n    = 1'b1;
            rd_addr_n  = req_addr;
            state_next = S_RD;
          end
          // be == 0: accepted and dropped, no memory activity.
        end
      end
      S_RD: state_next = S_MRG;
      S_MRG: begin
        if (rd_double_err) begin
          abort_n    = 1'b1;
          state_next = S_IDLE;
        end else begin
          wr_en_n    = 1'b1;
          wr_addr_n  = lat_addr;
          wr_data_n  = merged;
          corr_n     = rd_single_err;
          state_next = S_WR;
        end
      end
      S_WR:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef RVECC_ERR_INJECT_EN
  logic       inj_armed;
  logic [5:0] inj_idx;

  always_comb begin
    inj_mask = '0;
    if (inj_armed && wr_en_n) inj_mask = 39'd1 << inj_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_armed <= 1'b0;
      inj_idx   <= '0;
    end else begin
      // The arm is consumed by the write it corrupts; a fresh arm pulse in the
      // same cycle wins and applies to the following write.
      if (wr_en_n) inj_armed <= 1'b0;
      if (inj_arm && (inj_bit <= 6'd38)) begin
        inj_armed <= 1'b1;
        inj_idx   <= inj_bit;
      end
    end
  end
`else
  assign inj_mask = '0;
`endif

  assign cw_n = {ecc_encode(wr_data_n), wr_data_n} ^ inj_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_be        <= '0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      mem_wr_ecc    <= '0;
      rmw_corrected <= 1'b0;
      rmw_abort     <= 1'b0;
    end else begin
      state         <= state_next;
      mem_rd_en     <= rd_en_n;
      mem_rd_addr   <= rd_addr_n;
      mem_wr_en     <= wr_en_n;
      mem_wr_addr   <= wr_addr_n;
      mem_wr_data   <= cw_n[31:0];
      mem_wr_ecc    <= cw_n[38:32];
      rmw_corrected <= corr_n;
      rmw_abort     <= abort_n;
      if (lat_load) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
    end
  end

  assign req_ready = (state == S_IDLE) & ~rst;

endmodule

// File: tb/tb_rvecc_encode_wr.sv
// Testbench for rvecc_encode_wr: directed timing checks from the test plan,
// then randomized stores checked against a reference model (in-order shadow
// memory + bit-list ECC) through an expected-event queue.

module tb_rvecc_encode_wr;

  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   rd_data;
  logic          rd_single_err, rd_double_err;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [6:0]    mem_wr_ecc;
  logic          rmw_corrected, rmw_abort;
`ifdef RVECC_ERR_INJECT_EN
  logic          inj_arm;
  logic [5:0]    inj_bit;
`endif

  rvecc_encode_wr #(.AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .rd_data       (rd_data),
    .rd_single_err (rd_single_err),
    .rd_double_err (rd_double_err),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ecc    (mem_wr_ecc),
    .rmw_corrected (rmw_corrected),
    .rmw_abort     (rmw_abort)
`ifdef RVECC_ERR_INJECT_EN
    ,
    .inj_arm       (inj_arm),
    .inj_bit       (inj_bit)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  bit mon_en  = 1'b0;

  // Event entry: {is_abort, corrected, addr[15:0], data[31:0], ecc[6:0]}
  logic [56:0] exp_q[$];
  // Read entry: {addr[15:0], err[1:0]}  err: 0 clean, 1 single, 2 double
  logic [17:0] rd_q[$];

  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] sram    [logic [15:0]];

  bit          inj_pending = 1'b0;
  int          inj_idx     = 0;

  logic [31:0] nxt_rd;
  logic [1:0]  nxt_err;
  bit          nxt_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [6:0] e = '0;
    for (int i = 0; i < 32; i++) begin
      if (i inside {0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30}) e[0] ^= d[i];
      if (i inside {0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31}) e[1] ^= d[i];
      if (i inside {1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31}) e[2] ^= d[i];
      if (i inside {[4:10],[18:25]}) e[3] ^= d[i];
      if (i inside {[11:25]})        e[4] ^= d[i];
      if (i >= 26)                   e[5] ^= d[i];
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic push_write(input logic [15:0] a, input logic [31:0] d, input logic corr);
    logic [38:0] cw;
    cw = {ref_ecc(d), d};
    if (inj_pending) begin
      cw[inj_idx] = ~cw[inj_idx];
      inj_pending = 1'b0;
    end
    ref_mem[a] = cw[31:0];
    exp_q.push_back({1'b0, corr, a, cw[31:0], cw[38:32]});
  endtask

  // Called at the moment the bench sees a store handshake.
  task automatic model_accept(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                              input int err, input bit discard);
    logic [31:0] m;
    logic [31:0] merged;
    if (be == 4'hF) begin
      push_write(a, d, 1'b0);
    end else if (be != 4'h0) begin
      rd_q.push_back({a, 2'(err)});
      if (!discard) begin
        if (err == 2) begin
          exp_q.push_back({1'b1, 1'b0, 16'h0, 32'h0, 7'h0});
        end else begin
          m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
          merged = (d & m) | (ref_read(a) & ~m);
          push_write(a, merged, err == 1);
        end
      end
    end
  endtask

  // ---------------- SRAM model + monitor (negedge) ----------------
  always @(negedge clk) begin
    logic [17:0] r;
    logic [56:0] e;
    // Write-before-read: this cycle's write is visible to this cycle's read.
    if (mem_wr_en) sram[mem_wr_addr] = mem_wr_data;
    nxt_valid = 1'b0;
    if (mon_en) begin
      if (!mem_wr_en) check("wr_idle_zero", {mem_wr_addr, mem_wr_data, mem_wr_ecc}, 64'h0);
      if (mem_rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          check("unexpected_rd", mem_rd_en, 1'b0);
        end else begin
          r = rd_q.pop_front();
          check("rd_addr", mem_rd_addr, r[17:2]);
          nxt_rd    = sram.exists(mem_rd_addr) ? sram[mem_rd_addr] : 32'h0;
          nxt_err   = r[1:0];
          nxt_valid = 1'b1;
        end
      end
      if (mem_wr_en) wr_cnt++;
      if (mem_wr_en || rmw_abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {mem_wr_en, rmw_abort}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("ev_is_abort", rmw_abort, e[56]);
          if (e[56]) begin
            check("abort_no_wr", mem_wr_en, 1'b0);
          end else begin
            check("wr_addr", mem_wr_addr, e[54:39]);
            check("wr_data", mem_wr_data, e[38:7]);
            check("wr_ecc", mem_wr_ecc, e[6:0]);
            check("wr_corrected", rmw_corrected, e[55]);
          end
        end
      end else begin
        check("no_stray_corrected", rmw_corrected, 1'b0);
      end
    end
  end

  // Read data is presented for the cycle after mem_rd_en; garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (nxt_valid) begin
      rd_data       = nxt_rd;
      rd_single_err = (nxt_err == 2'd1);
      rd_double_err = (nxt_err == 2'd2);
    end else begin
      rd_data       = $urandom;
      rd_single_err = 1'b0;
      rd_double_err = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Call just after a rising edge; returns just after the accepting edge.
  task automatic do_store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int err, input bit discard, output int acc);
    int waited = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    acc = cyc;
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1'b1);
      acc = -1;
    end else begin
      model_accept(a, d, be, err, discard);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic full_word_test(input logic [15:0] a, input logic [31:0] d, input logic [6:0] exp_ecc);
    int acc;
    do_store(a, d, 4'hF, 0, 1'b0, acc);
    @(negedge clk);
    check("fw_latency", cyc - acc, 64'd1);
    check("fw_wr_en", mem_wr_en, 1'b1);
    check("fw_ecc", mem_wr_ecc, exp_ecc);
    check("fw_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Partial store with cycle-exact checks of N+1..N+4.
  task automatic rmw_test(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int err, input bit chk_data, input logic [31:0] exp_d,
                          input logic [6:0] exp_e);
    int acc;
    do_store(a, d, be, err, 1'b0, acc);
    @(negedge clk);                               // N+1
    check("rmw_rd_lat", cyc - acc, 64'd1);
    check("rmw_rd_en", mem_rd_en, 1'b1);
    check("rmw_rd_addr", mem_rd_addr, a);
    check("rmw_ready_n1", req_ready, 1'b0);
    @(negedge clk);                               // N+2
    check("rmw_ready_n2", req_ready, 1'b0);
    check("rmw_wr_n2", {mem_wr_en, rmw_abort}, 2'b00);
    @(negedge clk);                               // N+3
    if (err == 2) begin
      check("abort_pulse", rmw_abort, 1'b1);
      check("abort_wr_en", mem_wr_en, 1'b0);
      check("abort_ready_n3", req_ready, 1'b1);
    end else begin
      check("rmw_wr_en", mem_wr_en, 1'b1);
      check("rmw_corr_pulse", rmw_corrected, err == 1);
      check("rmw_abort_n3", rmw_abort, 1'b0);
      check("rmw_ready_n3", req_ready, 1'b0);
      if (chk_data) begin
        check("rmw_data", mem_wr_data, exp_d);
        check("rmw_ecc", mem_wr_ecc, exp_e);
      end
      @(negedge clk);                             // N+4
      check("rmw_ready_n4", req_ready, 1'b1);
      check("rmw_wr_n4", mem_wr_en, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef RVECC_ERR_INJECT_EN
  task automatic arm_inj(input logic [5:0] b);
    inj_arm = 1'b1;
    inj_bit = b;
    if (b <= 6'd38) begin
      inj_pending = 1'b1;
      inj_idx     = int'(b);
    end
    @(posedge clk);
    #1;
    inj_arm = 1'b0;
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int w0, r0, waited;
    logic [3:0] be;
    int err, sel;

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    rd_data = '0;
    rd_single_err = 1'b0;
    rd_double_err = 1'b0;
`ifdef RVECC_ERR_INJECT_EN
    inj_arm = 1'b0;
    inj_bit = '0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_strobes", {mem_rd_en, mem_wr_en, rmw_corrected, rmw_abort}, 4'h0);
    check("rst_outputs", {mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_ecc}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Full-word known codes
    full_word_test(16'h0010, 32'h0000_0000, 7'h00);
    full_word_test(16'h0011, 32'hFFFF_FFFF, 7'h18);
    full_word_test(16'h0012, 32'h0000_0001, 7'h43);

    // Five back-to-back full-word stores
    req_valid = 1'b1;
    req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      req_addr  = 16'h0020 + 16'(i);
      req_wdata = $urandom;
      @(negedge clk);
      check("b2b_ready", req_ready, 1'b1);
      if (i > 0) check("b2b_wr", mem_wr_en, 1'b1);
      model_accept(req_addr, req_wdata, 4'hF, 0, 1'b0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_wr", mem_wr_en, 1'b1);
    @(posedge clk);
    #1;

    // Partial store onto a zero word
    rmw_test(16'h0100, 32'h1234_56FF, 4'b0001, 0, 1'b1, 32'h0000_00FF, 7'h03);
    // Single-bit corrected read
    rmw_test(16'h0011, 32'hA5A5_A5A5, 4'b0110, 1, 1'b0, 32'h0, 7'h0);
    // Uncorrectable read
    rmw_test(16'h0012, 32'h5A5A_5A5A, 4'b1000, 2, 1'b0, 32'h0, 7'h0);

    // be = 0: accepted, no memory activity
    w0 = wr_cnt;
    r0 = rd_cnt;
    do_store(16'h0030, 32'hDEAD_BEEF, 4'h0, 0, 1'b0, acc);
    @(negedge clk);
    check("be0_ready", req_ready, 1'b1);
    idle(4);
    check("be0_no_wr", wr_cnt, w0);
    check("be0_no_rd", rd_cnt, r0);

    // Reset while the RMW is in its merge cycle
    w0 = wr_cnt;
    do_store(16'h0040, 32'h1111_2222, 4'b0011, 0, 1'b1, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", req_ready, 1'b1);
    check("midrst_no_wr", mem_wr_en, 1'b0);
    idle(4);
    check("midrst_wr_cnt", wr_cnt, w0);

`ifdef RVECC_ERR_INJECT_EN
    arm_inj(6'd35);
    full_word_test(16'h0200, 32'h0000_0000, 7'h08);
    full_word_test(16'h0201, 32'h0000_0000, 7'h00);
    arm_inj(6'd45);
    full_word_test(16'h0202, 32'h0000_0000, 7'h00);
`endif

    // Randomized mix on a small address range to exercise write/read hazards
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       be = 4'hF;
      else if (sel == 4) be = 4'h0;
      else               be = 4'($urandom_range(1, 14));
      sel = $urandom_range(0, 9);
      err = (sel < 7) ? 0 : (sel < 9) ? 1 : 2;
      do_store(16'($urandom_range(0, 7)), $urandom, be, err, 1'b0, acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Drain
    waited = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    idle(2);
    check("drain_events", exp_q.size(), 64'd0);
    check("drain_reads", rd_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvecc_encode_wr.md
# rvecc_encode_wr

Write-path SECDED encoder for ECC-protected 32-bit SRAM. It generates the 7-bit (39,32) check code for every store, and the code matches the one the existing read-path decoder checks. Byte-masked (partial) stores are handled by a read-modify-write sequence whose read data arrives already corrected from the read-path decoder. The block sits between the LSU/DMA store port and the SRAM write port.

## Interface
- AW, 16, word address width
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  store request valid
- req_ready  out  1  store request accepted when high with req_valid
- req_addr  in  AW  word address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit k covers wdata[8k+7:8k]
- mem_rd_en  out  1  SRAM read strobe (RMW)
- mem_rd_addr  out  AW  SRAM read address
- rd_data  in  32  corrected read data, valid the cycle after mem_rd_en
- rd_single_err  in  1  read data was single-bit corrected
- rd_double_err  in  1  read data uncorrectable
- mem_wr_en  out  1  SRAM write strobe
- mem_wr_addr  out  AW  SRAM write address
- mem_wr_data  out  32  write data
- mem_wr_ecc  out  7  write check bits
- rmw_corrected  out  1  one-cycle pulse: RMW used corrected old data
- rmw_abort  out  1  one-cycle pulse: RMW dropped on double error

## Operation
- Encoding of data d into ecc[6:0]. Each of ecc[5:0] is the XOR of the listed data bits:
  - ecc[0]: 0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30
  - ecc[1]: 0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31
  - ecc[2]: 1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31
  - ecc[3]: 4–10, 18–25
  - ecc[4]: 11–25
  - ecc[5]: 26–31
  - ecc[6]: ^d ^ ^ecc[5:0], so the parity of the full 39-bit codeword is even.
- FSM states:
  - IDLE: req_ready=1.
    - be==4'hF: encode and register the write; stay in IDLE.
    - be==0: accept and drop; no memory activity.
    - Any other be: latch addr/wdata/be and go to RD.
  - RD: mem_rd_en=1, mem_rd_addr=latched addr; go to MRG.
  - MRG: sample rd_data and the error flags.
    - rd_double_err=1: register rmw_abort; go to IDLE; no write.
    - Otherwise: merge bytes (be=1 takes the new byte, be=0 takes the rd_data byte), encode, register the write and rmw_corrected=rd_single_err; go to WR.
  - WR: mem_wr_en asserted from the register; go to IDLE.
- req_ready = (state==IDLE) & ~rst.
- Stores complete strictly in acceptance order. A full-word write issued the cycle before an RMW read to the same address is visible to that read, because the SRAM is write-before-read.

## Timing
- Reset values:
  - mem_rd_en, mem_wr_en, rmw_corrected, rmw_abort = 0.
  - Address and data outputs = 0.
  - state = IDLE.
  - req_ready = 0 while rst is high.
- Full-word store accepted at cycle N: mem_wr_en at N+1. Back-to-back throughput is 1 per cycle.
- Partial store accepted at N:
  - mem_rd_en at N+1; rd_data sampled at N+2.
  - mem_wr_en and rmw_corrected at N+3.
  - req_ready low N+1..N+3; next acceptance at N+4 at the earliest.
- Double error on the RMW read: rmw_abort at N+3 with mem_wr_en=0; req_ready high at N+3.
- All outputs are single-cycle pulses; write outputs are held only in their strobe cycle.
- rst asserted mid-RMW: the pending write is discarded, no strobe is issued, and the block is in IDLE the cycle after rst deasserts.

## Configuration
- RVECC_ERR_INJECT_EN defined:
  - Adds inputs inj_arm (1) and inj_bit (6).
  - A pulse on inj_arm arms injection at codeword index inj_bit, where 0–31 selects data bits and 32–38 selects ecc[0..6].
  - The next mem_wr_en flips that one bit, then the arm clears.
  - inj_bit > 38 is ignored.
  - rst clears the arm.
- Not defined: no extra ports; writes are always clean.

## Test plan
- Full-word store, wdata 0x00000000 → mem_wr_ecc 7'h00; wdata 0xFFFFFFFF → 7'h18; wdata 0x00000001 → 7'h43. Each write at N+1.
- Five full-word stores with req_valid held high → five consecutive mem_wr_en cycles, in order, with req_ready held at 1.
- SRAM word is 0x00000000; store be=4'b0001, wdata 0x123456FF → mem_rd_en at N+1, write at N+3 of 0x000000FF with ecc 7'h03; no error pulses.
- RMW with rd_single_err=1 → write at N+3 plus rmw_corrected pulse. RMW with rd_double_err=1 → rmw_abort at N+3, no mem_wr_en, req_ready high at N+3.
- be=0 → accepted, with no rd/wr strobes. rst asserted in MRG → no write, and IDLE after release.
- With RVECC_ERR_INJECT_EN: arm inj_bit=35, write 0x00000000 → mem_wr_ecc 7'h08; the following write is clean.
